// File: rtl/uart_rx_if.sv
// uart_rx_if: tick strobe, serial line and received-byte outputs of uart_rx.
// The slave modport is the receiver's view; the master modport is the view of
// whatever feeds the line and consumes the received bytes.
// Optional feature macro: UART_RX_PARITY_EN (adds o_parity_err).
interface uart_rx_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_rx;
  logic [NB_DATA-1:0] o_data;
  logic               o_rxDone;
  logic               o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic               o_parity_err;
`endif

  modport slave (
    input  i_tick,
    input  i_rx,
    output o_data,
    output o_rxDone,
    output o_frame_err
`ifdef UART_RX_PARITY_EN
    , output o_parity_err
`endif
  );

  modport master (
    output i_tick,
    output i_rx,
    input  o_data,
    input  o_rxDone,
    input  o_frame_err
`ifdef UART_RX_PARITY_EN
    , input  o_parity_err
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB-first frames.
// Each completed frame updates o_data / o_frame_err and pulses o_rxDone for
// one clk, even when the stop bit is bad.
// Optional feature macro: UART_RX_PARITY_EN (parity bit between data and stop,
// parameter PARITY_ODD, output o_parity_err). The interface instance must use
// the same NB_DATA as this module.
module uart_rx #(
  parameter int NB_DATA     = 8,
  parameter int NB_STOP     = 16,
  parameter int NB_TICK_CNT = 4
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     i_rst_n,
  uart_rx_if.slave rx_if
);

  localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  localparam logic [NB_TICK_CNT-1:0] MID_TICK  = NB_TICK_CNT'(7);
  localparam logic [NB_TICK_CNT-1:0] LAST_TICK = NB_TICK_CNT'(15);
  localparam logic [NB_TICK_CNT-1:0] STOP_TICK = NB_TICK_CNT'(NB_STOP - 1);
  localparam logic [NB_BIT_CNT-1:0]  LAST_BIT  = NB_BIT_CNT'(NB_DATA - 1);

  logic                   rx_meta_reg, rx_s_reg;
  logic [2:0]             state_reg, state_next;
  logic [NB_TICK_CNT-1:0] tick_cnt_reg, tick_cnt_next;
  logic [NB_BIT_CNT-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [NB_DATA-1:0]     shift_reg, shift_next;
  logic [NB_DATA-1:0]     data_reg, data_next;
  logic                   done_reg, done_next;
  logic                   frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                   parity_reg, parity_next;
  logic                   parity_err_reg, parity_err_next;
`endif

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_if.i_rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // Frame FSM: everything but the start-edge detect waits for a baud tick.
  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    done_next      = 1'b0;
    frame_err_next = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    parity_next     = parity_reg;
    parity_err_next = parity_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (rx_if.i_tick) begin
          if (tick_cnt_reg == MID_TICK) begin
            // Still low at mid start bit: genuine start; otherwise a glitch.
            if (!rx_s_reg) begin
              state_next    = DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_if.i_tick) begin
          if (tick_cnt_reg == LAST_TICK) begin
            shift_next    = {rx_s_reg, shift_reg[NB_DATA-1:1]};
            tick_cnt_next = '0;
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (rx_if.i_tick) begin
          if (tick_cnt_reg == LAST_TICK) begin
            parity_next   = rx_s_reg;
            tick_cnt_next = '0;
            state_next    = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (rx_if.i_tick) begin
          if (tick_cnt_reg == STOP_TICK) begin
            // Leave at mid stop bit so an immediately following start edge is seen.
            data_next      = shift_reg;
            frame_err_next = ~rx_s_reg;
            done_next      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_next = ^shift_reg ^ parity_reg ^ PARITY_ODD;
`endif
            state_next     = IDLE;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress silently.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_reg     <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
      frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_reg     <= parity_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign rx_if.o_data      = data_reg;
  assign rx_if.o_rxDone    = done_reg;
  assign rx_if.o_frame_err = frame_err_reg;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = parity_err_reg;
`endif

endmodule
